cache_writeback_buffer: RTL
===========================

Name: cache_writeback_buffer

Overview:
- Drain side of cache eviction: accepts dirty victim lines evicted by the cache controller after replacement selects a victim way.
- Queues the lines in a small FIFO and writes each one to the bus as a fixed-length burst of AHBW-bit beats.
- Exposes a line-address probe so the miss-fill path stalls on any line still pending writeback.
- Sits between the cache FSM/data array and the bus write interface.

Parameters:
- PA_BITS, 34, physical address width.
- LINELEN, 512, cache line width in bits.
- AHBW, 64, bus data width in bits; LINELEN/AHBW = BEATS, a power of 2 and at least 2.
- DEPTH, 2, FIFO entries; a power of 2 and at least 2.

Ports:
- clk  in  1  clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- VictimValid  in  1  evicted dirty line presented.
- VictimReady  out  1  buffer can accept; equals ~Full.
- VictimAdr  in  PA_BITS  line address of the victim; offset bits are ignored and treated as zero.
- VictimLine  in  LINELEN  victim line data.
- BusReq  out  1  write beat valid.
- BusAck  in  1  bus accepts current beat.
- BusAdr  out  PA_BITS  beat address.
- BusWriteData  out  AHBW  beat data.
- BusLast  out  1  current beat is the final beat of the line.
- ProbeAdr  in  PA_BITS  address to check; compared at line granularity.
- ProbeHit  out  1  ProbeAdr matches a pending entry.
- Empty  out  1  no entries pending, including any in flight.

Behaviour:
- Reset state: read pointer = 0, write pointer = 0, FSM = IDLE, beat counter = 0, all entry valid bits cleared.
- Reset outputs: BusReq=0, BusLast=0, VictimReady=1, Empty=1, ProbeHit=0.
- Reset mid-burst aborts the burst and discards all entries. No further beats are issued.
- FIFO pointers are log2(DEPTH)+1 bits wide; the extra MSB is the wrap bit.
  - Full = (indices equal) & (wrap bits differ).
  - Empty = pointers equal.
- Push occurs on (VictimValid & VictimReady). Adr and Line are captured at that clock edge.
- No push-while-full bypass: VictimReady depends only on Full, even in a cycle where a pop occurs.
- FSM states are IDLE and BURST.
  - IDLE: go to BURST when the FIFO is not empty. Beat counter is held at 0.
  - BURST: BusReq=1.
  - BusAdr = {head line address, offset}, where offset = beat × AHBW/8.
  - BusWriteData = head line[beat×AHBW +: AHBW]; beat 0 is the least significant slice.
  - BusLast = (beat == BEATS-1).
  - BusReq & BusAck & ~BusLast: beat counter increments.
  - BusReq & BusAck & BusLast: pop head, beat counter returns to 0. Go to BURST if another entry remains after the pop, else IDLE. No idle gap between consecutive lines.
  - BusAck without BusReq is ignored.
- BusReq, BusAdr, BusWriteData and BusLast hold stable while BusReq=1 and BusAck=0.
- Latency: a push at edge N into an empty, idle buffer gives BusReq=1 in the cycle after edge N+1.
- Simultaneous push and final-beat pop (not full) are both performed. The count is unchanged.
- ProbeHit is combinational: the line-aligned ProbeAdr equals the address of any valid entry.
  - This includes the head entry during its burst, until its final beat is acked.
  - An entry being pushed in the same cycle does not count.
  - ProbeHit is 0 when Empty.
- Duplicate addresses are legal. Entries drain in FIFO order.

Decomposition:
- Shared cache package holds the state typedef wbstate_t {WB_IDLE, WB_BURST} and localparams BEATS, LOGBEATS and OFFSETLEN derived from the parameters.
- One sub-module, cache_wb_fifo, holds storage, pointers, Full/Empty and the per-entry address compare vector.
- The FSM, beat counter and beat slicing stay in the top level.

Test Plan:
- Reset, then a single push with VictimAdr=0x1000 and line beat k=k+1, BusAck held at 1. Required: after 2 cycles, 8 beats at BusAdr 0x1000, 0x1008 … 0x1038 with data 1…8; BusLast only on beat 8; Empty=1 afterwards.
- Push 0x2000 then 0x3000 back-to-back, BusAck stalled for 3 cycles on beat 2. Required: outputs hold while stalled; VictimReady=0 after the second push; the second line's beat 0 follows the first line's last ack with no gap.
- Buffer full, VictimValid=1 during the final-beat ack cycle. Required: VictimReady=0 in that cycle and no push; the push is accepted the next cycle.
- With 0x4000 in flight, ProbeAdr=0x4020. Required: ProbeHit=1 through the last ack, 0 the cycle after. ProbeAdr=0x4040 gives 0 throughout.
- Push a line, then assert reset during beat 3. Required: the next cycle shows BusReq=0, Empty=1, VictimReady=1, and no further beats.
- Simultaneous push of 0x5000 with final-beat pop of 0x6000 at count 1. Required: count stays 1; 0x5000's beats start immediately.

Source files
------------

// File: rtl/cache_writeback_buffer_pkg.sv
// Shared definitions for the cache writeback buffer.
// Holds the drain FSM state type and the beat/offset geometry that the
// default parameter set implies. Modules that take these as parameters
// derive their own copies so that overrides stay consistent.
package cache_writeback_buffer_pkg;

    localparam int unsigned PA_BITS_DEF = 34;
    localparam int unsigned LINELEN_DEF = 512;
    localparam int unsigned AHBW_DEF    = 64;
    localparam int unsigned DEPTH_DEF   = 2;

    localparam int unsigned BEATS     = LINELEN_DEF / AHBW_DEF;
    localparam int unsigned LOGBEATS  = $clog2(BEATS);
    localparam int unsigned OFFSETLEN = $clog2(LINELEN_DEF / 8);

    typedef enum logic {
        WB_IDLE,
        WB_BURST
    } wbstate_t;

endpackage

// File: rtl/cache_writeback_buffer_if.sv
// Bus write-beat interface between the writeback buffer and the bus.
//   BusReq       beat valid (master -> slave)
//   BusAck       beat accepted (slave -> master)
//   BusAdr       beat byte address
//   BusWriteData beat data
//   BusLast      final beat of the current line
interface cache_writeback_buffer_if #(
    parameter int unsigned PA_BITS = 34,
    parameter int unsigned AHBW    = 64
);
    logic               BusReq;
    logic               BusAck;
    logic [PA_BITS-1:0] BusAdr;
    logic [AHBW-1:0]    BusWriteData;
    logic               BusLast;

    modport master (
        output BusReq, BusAdr, BusWriteData, BusLast,
        input  BusAck
    );

    modport slave (
        input  BusReq, BusAdr, BusWriteData, BusLast,
        output BusAck
    );
endinterface

// File: rtl/cache_wb_fifo.sv
// Victim line FIFO for the writeback buffer.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   push, push_tag/line push a line (tag = line-aligned address bits)
//   pop                 retire the head entry
//   head_tag, head_line head entry contents
//   full, empty         occupancy flags; one_left = exactly one entry
//   probe_tag, match    per-entry compare of probe_tag against valid entries
module cache_wb_fifo #(
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned TAGW    = 28,
    parameter int unsigned LINELEN = 512
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [TAGW-1:0]    push_tag,
    input  logic [LINELEN-1:0] push_line,
    input  logic               pop,
    output logic [TAGW-1:0]    head_tag,
    output logic [LINELEN-1:0] head_line,
    output logic               full,
    output logic               empty,
    output logic               one_left,
    input  logic [TAGW-1:0]    probe_tag,
    output logic [DEPTH-1:0]   match
);
    localparam int unsigned IDXW = $clog2(DEPTH);

    // Pointers carry one extra MSB as the wrap bit.
    logic [IDXW:0]        rd_ptr, wr_ptr;
    logic [TAGW-1:0]      tags  [DEPTH];
    logic [LINELEN-1:0]   lines [DEPTH];
    logic [DEPTH-1:0]     valid;
    logic [IDXW-1:0]      rd_idx, wr_idx;

    assign rd_idx = rd_ptr[IDXW-1:0];
    assign wr_idx = wr_ptr[IDXW-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            valid  <= '0;
        end else begin
            // Push is never allowed while full, so the two indices differ
            // whenever both happen in one cycle.
            if (push) begin
                valid[wr_idx] <= 1'b1;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (pop) begin
                valid[rd_idx] <= 1'b0;
                rd_ptr        <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            tags[wr_idx]  <= push_tag;
            lines[wr_idx] <= push_line;
        end
    end

    assign head_tag  = tags[rd_idx];
    assign head_line = lines[rd_idx];
    assign empty     = (rd_ptr == wr_ptr);
    assign full      = (rd_idx == wr_idx) && (rd_ptr[IDXW] != wr_ptr[IDXW]);
    assign one_left  = ((wr_ptr - rd_ptr) == (IDXW + 1)'(1));

    always_comb begin
        match = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            match[i] = valid[i] && (tags[i] == probe_tag);
        end
    end

endmodule

// File: rtl/cache_writeback_buffer.sv
// Cache writeback buffer: queues dirty victim lines and drains each one to
// the bus as a fixed-length burst of AHBW-bit beats, lowest slice first.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   VictimValid/Ready     victim push handshake (Ready = not full)
//   VictimAdr, VictimLine victim line address (offset ignored) and data
//   bus                   bus write-beat interface (master side)
//   ProbeAdr, ProbeHit    line-granular check against pending entries
//   Empty                 nothing pending, including the line in flight
module cache_writeback_buffer
    import cache_writeback_buffer_pkg::*;
#(
    parameter int unsigned PA_BITS = PA_BITS_DEF,
    parameter int unsigned LINELEN = LINELEN_DEF,
    parameter int unsigned AHBW    = AHBW_DEF,
    parameter int unsigned DEPTH   = DEPTH_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                VictimValid,
    output logic                VictimReady,
    input  logic [PA_BITS-1:0]  VictimAdr,
    input  logic [LINELEN-1:0]  VictimLine,
    cache_writeback_buffer_if.master bus,
    input  logic [PA_BITS-1:0]  ProbeAdr,
    output logic                ProbeHit,
    output logic                Empty
);
    localparam int unsigned NBEATS   = LINELEN / AHBW;
    localparam int unsigned BEATW    = $clog2(NBEATS);
    localparam int unsigned LINE_OFF = $clog2(LINELEN / 8);
    localparam int unsigned BYTE_OFF = $clog2(AHBW / 8);
    localparam int unsigned TAGW     = PA_BITS - LINE_OFF;

    wbstate_t           state, next_state;
    logic [BEATW-1:0]   beat;
    logic               full, fifo_empty, one_left;
    logic               push, pop, ack, beat_last;
    logic [TAGW-1:0]    head_tag;
    logic [LINELEN-1:0] head_line;
    logic [DEPTH-1:0]   match;
    logic               unused_offsets;

    assign unused_offsets = ^{VictimAdr[LINE_OFF-1:0], ProbeAdr[LINE_OFF-1:0]};

    assign push        = VictimValid && !full;
    assign VictimReady = !full;
    assign beat_last   = (beat == BEATW'(NBEATS - 1));
    assign ack         = (state == WB_BURST) && bus.BusAck;
    assign pop         = ack && beat_last;

    cache_wb_fifo #(
        .DEPTH   (DEPTH),
        .TAGW    (TAGW),
        .LINELEN (LINELEN)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_tag  (VictimAdr[PA_BITS-1:LINE_OFF]),
        .push_line (VictimLine),
        .pop       (pop),
        .head_tag  (head_tag),
        .head_line (head_line),
        .full      (full),
        .empty     (fifo_empty),
        .one_left  (one_left),
        .probe_tag (ProbeAdr[PA_BITS-1:LINE_OFF]),
        .match     (match)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= WB_IDLE;
            beat  <= '0;
        end else begin
            state <= next_state;
            if (ack) begin
                beat <= beat_last ? '0 : beat + 1'b1;
            end
        end
    end

    always_comb begin
        next_state       = state;
        bus.BusReq       = 1'b0;
        bus.BusLast      = 1'b0;
        bus.BusAdr       = {head_tag, beat, BYTE_OFF'(0)};
        bus.BusWriteData = head_line[int'(beat) * AHBW +: AHBW];
        unique case (state)
            WB_IDLE: begin
                if (!fifo_empty) next_state = WB_BURST;
            end
            WB_BURST: begin
                bus.BusReq  = 1'b1;
                bus.BusLast = beat_last;
                // Stay in BURST across the pop when anything remains,
                // counting a same-cycle push, so lines go out gap-free.
                if (pop && one_left && !push) next_state = WB_IDLE;
            end
            default: next_state = WB_IDLE;
        endcase
    end

    assign ProbeHit = |match;
    assign Empty    = fifo_empty;

endmodule
